// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the MEM-stage load/store port. Accepts one
//   request at a time, waits a fixed number of cycles, commits the enabled
//   byte lanes and returns the word as it was before the write
//   (read-before-write). Lane shifting for sub-word accesses is done in the
//   MEM stage, not here.
//
// Parameters
//   DEPTH_BYTES  memory size in bytes (multiple of 4)
//   WAIT_STATES  extra cycles between accept and response (0..15)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  request present
//   req_ready  responder can accept (IDLE only)
//   req_addr   byte address, bits [1:0] ignored
//   req_be     byte write enables, be[i] -> byte addr+i
//   req_wdata  write data, [8i+7:8i] -> byte addr+i
//   req_read   return the pre-write word in the response
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  {mem[a+3],mem[a+2],mem[a+1],mem[a]}
//   busy       request outstanding
//   bus_err    out-of-range flag (only with DMEM_RANGE_CHECK_EN)
//
// Build option
//   DMEM_RANGE_CHECK_EN : when defined, addresses >= DEPTH_BYTES do not
//   write, return zero read data and raise bus_err with rsp_valid. When
//   undefined, the upper address bits simply wrap.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_BYTES = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic        req_read,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        bus_err
`endif
);

    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [3:0]         be_r;
    logic [31:0]        wdata_r;
    logic               read_r;

    logic               req_ready_r;
    logic               rsp_valid_r;
    logic               busy_r;
    logic [31:0]        rsp_rdata_r;

    logic               accept_s;
    logic               commit_s;
    logic               in_range_s;
    logic               unused_addr_s;

    // Word storage: not reset, zero at time 0 only.
    logic [31:0]        mem_r [DEPTH_WORDS] = '{default: 32'h0000_0000};

    // Byte-offset bits and wrapped-away upper bits carry no meaning here.
    assign unused_addr_s = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

    assign accept_s = req_valid && (state_r == ST_IDLE);
    // The commit edge is the WAIT->RESP transition.
    assign commit_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);

`ifdef DMEM_RANGE_CHECK_EN
    logic oor_r;
    logic bus_err_r;

    // Latch whether the accepted request falls outside the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_r <= 1'b0;
        end else if (accept_s) begin
            oor_r <= (req_addr >= 32'(DEPTH_BYTES));
        end
    end

    assign in_range_s = ~oor_r;

    // bus_err is raised only in the RESP cycle of an out-of-range request.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= (state_nxt_s == ST_RESP) && oor_r;
        end
    end

    assign bus_err = bus_err_r;
`else
    assign in_range_s = 1'b1;
`endif

    // Next-state logic for IDLE -> WAIT -> RESP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Wait-state counter: loaded at accept, counts down while in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= 4'(WAIT_STATES);
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Request capture; inputs are ignored at all other times.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            be_r    <= 4'h0;
            wdata_r <= 32'h0000_0000;
            read_r  <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= req_addr[IDX_W+1:2];
            be_r    <= req_be;
            wdata_r <= req_wdata;
            read_r  <= req_read;
        end
    end

    // Byte-lane write on the commit edge; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && in_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    // Read data captured on the commit edge from the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_r <= 32'h0000_0000;
        end else if (commit_s && read_r) begin
            if (in_range_s) begin
                rsp_rdata_r <= mem_r[idx_r];
            end else begin
                rsp_rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule
